// File: rtl/dmem_pkg.sv
// Shared types and lane-mask helper for the byte-lane-banked data memory.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} sz_t;
  typedef enum logic {IDLE, SPLIT} state_t;

  typedef struct packed {
    logic [7:0] p1;
    logic [7:0] p2;
  } bmask_t;

  // Lanes touched in the accept phase (p1) and in the next row (p2).
  function automatic bmask_t byte_mask(input logic [2:0] offset, input logic [1:0] size,
                                       input logic [3:0] nb);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << offset;
    byte_mask.p1 = 8'(m) & ~(8'hFF << nb);
    byte_mask.p2 = 8'(m >> nb);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide lane: synchronous write, combinational read.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_banked.sv
// Byte-lane-banked data memory; row-crossing accesses take a second SPLIT cycle.
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int NB     = 4,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_sz,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [8*NB-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [8*NB-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int DW    = 8 * NB;
  localparam int OFF_W = $clog2(NB);
  localparam int ROW_W = ADDR_W - OFF_W;

  state_t           state;
  logic             fire, err, split;
  logic [3:0]       nbytes;
  logic [ADDR_W:0]  end_a;
  logic [OFF_W-1:0] off;
  logic [ROW_W-1:0] row;
  bmask_t           bm;
  logic [NB-1:0]    p1, p2;
  logic [2*DW-1:0]  wd2;

  // Latched request for the second phase, plus first-phase read row.
  logic [OFF_W-1:0] l_off;
  sz_t              l_sz;
  logic             l_uns, l_we;
  logic [ROW_W-1:0] l_row2;
  logic [NB-1:0]    l_p2;
  logic [DW-1:0]    l_wd_hi, hold;

  logic [NB-1:0]       lane_we;
  logic [ROW_W-1:0]    bank_addr;
  logic [NB-1:0][7:0]  lane_wd, lane_rd;

  assign req_ready = rst_n && (state == IDLE);
  assign fire      = req_valid && req_ready;

  always_comb begin
    nbytes = 4'd1 << req_sz;
    end_a  = {1'b0, req_addr} + (ADDR_W+1)'(nbytes - 4'd1);
    err    = (nbytes > 4'(NB)) || (end_a > (ADDR_W+1)'(DEPTH*NB - 1));
    off    = req_addr[OFF_W-1:0];
    row    = req_addr[ADDR_W-1:OFF_W];
    bm     = byte_mask(3'(off), req_sz, 4'(NB));
    p1     = NB'(bm.p1);
    p2     = NB'(bm.p2);
    split  = (|p2) && !err;
    wd2    = {{DW{1'b0}}, req_wdata} << {off, 3'b000};
  end

  always_comb begin
    if (state == SPLIT) begin
      bank_addr = l_row2;
      lane_we   = {NB{l_we}} & l_p2;
      lane_wd   = l_wd_hi;
    end else begin
      bank_addr = row;
      lane_we   = {NB{fire && req_we && !err}} & p1;
      lane_wd   = wd2[DW-1:0];
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    dmem_bank #(.DEPTH(DEPTH), .AW(ROW_W)) u_bank (
      .clk   (clk),
      .we    (lane_we[i]),
      .addr  (bank_addr),
      .wdata (lane_wd[i]),
      .rdata (lane_rd[i])
    );
  end

  // Load path: {second row, held first row} shifted down by offset, then extended.
  logic [2*DW-1:0]  comb_rd;
  logic [DW-1:0]    sh, ext;
  logic [OFF_W-1:0] cur_off;
  sz_t              cur_sz;
  logic             cur_uns, sb;
  logic [3:0]       cur_n;

  always_comb begin
    if (state == SPLIT) begin
      comb_rd = {lane_rd, hold};
      cur_off = l_off;
      cur_sz  = l_sz;
      cur_uns = l_uns;
    end else begin
      comb_rd = {{DW{1'b0}}, lane_rd};
      cur_off = off;
      cur_sz  = sz_t'(req_sz);
      cur_uns = req_unsigned;
    end
    sh    = DW'(comb_rd >> {cur_off, 3'b000});
    cur_n = 4'd1 << cur_sz;
    case (cur_sz)
      SZ_B:    sb = sh[7];
      SZ_H:    sb = sh[15];
      default: sb = sh[31];
    endcase
    ext = sh;
    for (int b = 0; b < NB; b++)
      if (4'(b) >= cur_n) ext[8*b +: 8] = cur_uns ? 8'h00 : {8{sb}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_off     <= '0;
      l_sz      <= SZ_B;
      l_uns     <= 1'b0;
      l_we      <= 1'b0;
      l_row2    <= '0;
      l_p2      <= '0;
      l_wd_hi   <= '0;
      hold      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (fire) begin
          if (split) begin
            state   <= SPLIT;
            l_off   <= off;
            l_sz    <= sz_t'(req_sz);
            l_uns   <= req_unsigned;
            l_we    <= req_we;
            l_row2  <= row + ROW_W'(1);
            l_p2    <= p2;
            l_wd_hi <= wd2[2*DW-1:DW];
            hold    <= lane_rd;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? '0 : ext;
          end
        end
        SPLIT: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= l_we ? '0 : ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_banked.sv
// Randomized and directed bench for dmem_banked against a flat byte-array model.
module tb_dmem_banked;

  localparam int NB = 4, DEPTH = 1024, AW = 12, MEMB = DEPTH * NB;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_sz = 2'd0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_vec = 0, n_bad = 0;
  logic [7:0] mm [MEMB];

  dmem_banked #(.NB(NB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_sz(req_sz), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_err(int a, int sz);
    return ((1 << sz) > NB) || (a + (1 << sz) > MEMB);
  endfunction

  function automatic logic [31:0] m_load(int a, int sz, bit uns);
    int n = 1 << sz;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v |= 32'(mm[a+i]) << (8*i);
    if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
    return v;
  endfunction

  function automatic void m_store(int a, int sz, logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) mm[a+i] = wd[8*i +: 8];
  endfunction

  // Issue one request at edge+1, return response and latency in cycles after acceptance.
  task automatic do_req(input bit we, input int sz, input bit uns, input int addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int rdy_lo);
    req_valid = 1'b1; req_we = we; req_sz = 2'(sz); req_unsigned = uns;
    req_addr = 12'(addr); req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rdy_lo = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; lat = k; break; end
      if (!req_ready) rdy_lo++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", rsp_err); end
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_reset got %b want 0", req_ready); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
  endtask

  task automatic init_mem();
    logic [31:0] rd, w; logic er; int lat, rl;
    for (int r = 0; r < DEPTH; r++) begin
      w = $urandom;
      do_req(1'b1, 2, 1'b0, 4*r, w, rd, er, lat, rl);
      m_store(4*r, 2, w);
    end
  endtask

  task automatic test_aligned_word();
    logic [31:0] rd; logic er; int lat, rl;
    do_req(1'b1, 2, 1'b0, 'h010, 32'hDEADBEEF, rd, er, lat, rl);
    m_store('h010, 2, 32'hDEADBEEF);
    n_vec++; if (er !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL sw_aligned err %b lat %0d want 0/1", er, lat); end
    do_req(1'b0, 2, 1'b0, 'h010, 32'd0, rd, er, lat, rl);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_aligned got %h want deadbeef", rd); end
    n_vec++; if (er !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL lw_aligned err %b lat %0d want 0/1", er, lat); end
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic er; int lat, rl;
    int          sz_t_[4]  = '{0, 0, 1, 1};
    bit          un_t[4]   = '{0, 1, 0, 1};
    int          ad_t[4]   = '{'h013, 'h013, 'h012, 'h010};
    logic [31:0] ex_t[4]   = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz_t_[i], un_t[i], ad_t[i], 32'd0, rd, er, lat, rl);
      n_vec++;
      if (rd !== ex_t[i] || er !== 1'b0) begin
        n_bad++; $display("FAIL ext_%0d got %h/%b want %h/0", i, rd, er, ex_t[i]);
      end
    end
  endtask

  task automatic test_split();
    logic [31:0] rd; logic er; int lat, rl;
    do_req(1'b1, 2, 1'b0, 'h01E, 32'h11223344, rd, er, lat, rl);
    m_store('h01E, 2, 32'h11223344);
    n_vec++; if (rl != 1 || lat != 2) begin n_bad++; $display("FAIL sw_split ready_low %0d lat %0d want 1/2", rl, lat); end
    n_vec++; if (er !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL sw_split rsp %h/%b want 0/0", rd, er); end
    do_req(1'b0, 2, 1'b0, 'h01E, 32'd0, rd, er, lat, rl);
    n_vec++; if (rd !== 32'h11223344 || lat != 2) begin n_bad++; $display("FAIL lw_split got %h lat %0d want 11223344/2", rd, lat); end
    do_req(1'b0, 1, 1'b1, 'h020, 32'd0, rd, er, lat, rl);
    n_vec++; if (rd !== 32'h00001122 || lat != 1) begin n_bad++; $display("FAIL lhu_next got %h lat %0d want 1122/1", rd, lat); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat, rl;
    int a_t[3] = '{'hFFE, 'hFFF, 'h000};
    do_req(1'b0, 2, 1'b0, 'hFFE, 32'd0, rd, er, lat, rl);
    n_vec++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin n_bad++; $display("FAIL lw_oor got %h/%b lat %0d want 0/1/1", rd, er, lat); end
    do_req(1'b1, 2, 1'b0, 'hFFE, 32'h5A5A5A5A, rd, er, lat, rl);
    n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL sw_oor err got %b want 1", er); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 0, 1'b1, a_t[i], 32'd0, rd, er, lat, rl);
      n_vec++; if (rd !== {24'd0, mm[a_t[i]]}) begin n_bad++; $display("FAIL oor_byte_%0d got %h want %h", i, rd, mm[a_t[i]]); end
    end
    do_req(1'b0, 3, 1'b0, 'h000, 32'd0, rd, er, lat, rl);
    n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL sz_double got %h/%b want 0/1", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex[4];
    for (int i = 0; i < 4; i++) ex[i] = m_load(64 + 4*i, 2, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_sz = 2'd2; req_unsigned = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 12'(64 + 4*i);
      n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d got %b want 1", i, req_ready); end
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ex[i]) begin
        n_bad++; $display("FAIL b2b_rsp_%0d got %b/%h want 1/%h", i, rsp_valid, rsp_rdata, ex[i]);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_split();
    logic [31:0] rd; logic er; int lat, rl;
    logic [7:0] prior = mm['h024];
    req_valid = 1'b1; req_we = 1'b1; req_sz = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h023; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_split_in got %b/%b want 0/0", rsp_valid, req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_split_valid got %b want 0", rsp_valid); end
    rst_n = 1'b1; #1;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_split_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_split_drop got %b want 0", rsp_valid); end
    mm['h023] = 8'hDD;
    do_req(1'b0, 0, 1'b1, 'h023, 32'd0, rd, er, lat, rl);
    n_vec++; if (rd !== 32'h000000DD) begin n_bad++; $display("FAIL rst_split_b0 got %h want dd", rd); end
    do_req(1'b0, 0, 1'b1, 'h024, 32'd0, rd, er, lat, rl);
    n_vec++; if (rd !== {24'd0, prior}) begin n_bad++; $display("FAIL rst_split_b1 got %h want %h", rd, prior); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exd; logic er; int lat, rl, a, sz, exl; bit we, un, exe;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(MEMB - 8, MEMB - 1);
        1:       a = 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        default: a = $urandom_range(0, MEMB - 1);
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      we = $urandom_range(0, 1); un = $urandom_range(0, 1); wd = $urandom;
      exe = m_err(a, sz);
      exd = (exe || we) ? 32'd0 : m_load(a, sz, un);
      exl = (!exe && ((a % NB) + (1 << sz) > NB)) ? 2 : 1;
      do_req(we, sz, un, a, wd, rd, er, lat, rl);
      if (!exe && we) m_store(a, sz, wd);
      n_vec++; if (er !== exe) begin n_bad++; $display("FAIL rnd_err it %0d a %h sz %0d got %b want %b", it, a, sz, er, exe); end
      n_vec++; if (rd !== exd) begin n_bad++; $display("FAIL rnd_data it %0d a %h sz %0d we %b got %h want %h", it, a, sz, we, rd, exd); end
      n_vec++; if (lat != exl) begin n_bad++; $display("FAIL rnd_lat it %0d a %h sz %0d got %0d want %0d", it, a, sz, lat, exl); end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_aligned_word();
    test_extension();
    test_split();
    test_out_of_range();
    test_back_to_back();
    test_reset_split();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
